// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline hazard controller for the 5-stage RV32I core.
//
// Purpose:
//   Produces the stall / flush / freeze controls for the IF/ID, ID/EX, EX/MEM
//   and MEM/WB pipeline registers and the EX-stage operand forwarding selects.
//   Load-use hazards get a single bubble, taken branches/jumps squash the two
//   younger instructions, and a data-memory hold-off freezes everything.
//   A small RUN/WAIT state machine times memory hold-offs and raises a sticky
//   TIMEOUT_ERR when a request waits MEM_TIMEOUT cycles.
//
// Parameters:
//   MEM_TIMEOUT  wait cycles in WAIT before TIMEOUT_ERR sets (>= 2)
//   CNT_W        width of the performance counters
//
// Ports:
//   CLK, RST_N                      clock, synchronous active-low reset
//   RS1_ID, RS2_ID                  source registers of the ID instruction
//   USES_RS1_ID, USES_RS2_ID        ID instruction really reads rs1 / rs2
//   RS1_DE, RS2_DE, RD_DE           register fields of the EX instruction
//   MemRead_DE                      nonzero = load in EX
//   RD_EM, RD_MW                    destinations in MEM / WB
//   RegWrite_EM, RegWrite_MW        write enables in MEM / WB
//   MemRead_EM, MemWrite_EM         nonzero = memory access in MEM
//   TAKEN_E                         branch/jump in EX resolved taken
//   DM_READY                        data memory completes access this cycle
//   stall_PC, stall_FD, stall_DE    hold PC / hold IF/ID / bubble into ID/EX
//   flush_FD, flush_DE              squash IF/ID / ID/EX
//   FREEZE                          hold every pipeline register and the PC
//   FWD_A, FWD_B                    00 regfile, 01 WB value, 10 EX/MEM ALU
//   TIMEOUT_ERR                     sticky memory-timeout flag
//   STALL_CNT, FLUSH_CNT, FREEZE_CNT performance counters
//
// Configuration macro:
//   HAZARD_PERF_CNT_EN  when defined, the three performance counters are
//                       built; otherwise the counter outputs are tied to 0.
// ============================================================================
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             USES_RS1_ID,
    input  logic             USES_RS2_ID,
    input  logic [4:0]       RS1_DE,
    input  logic [4:0]       RS2_DE,
    input  logic [4:0]       RD_DE,
    input  logic [1:0]       MemRead_DE,
    input  logic [4:0]       RD_EM,
    input  logic [4:0]       RD_MW,
    input  logic             RegWrite_EM,
    input  logic             RegWrite_MW,
    input  logic [1:0]       MemRead_EM,
    input  logic [1:0]       MemWrite_EM,
    input  logic             TAKEN_E,
    input  logic             DM_READY,
    output logic             stall_PC,
    output logic             stall_FD,
    output logic             stall_DE,
    output logic             flush_FD,
    output logic             flush_DE,
    output logic             FREEZE,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic             TIMEOUT_ERR,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic [CNT_W-1:0] FREEZE_CNT
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_err_q, timeout_err_d;

    logic memBusy;
    logic loadUse;

    // Forwarding select for one EX operand. A load in MEM has no ALU result
    // worth forwarding, so it is skipped and the WB copy (if any) is used.
    function automatic logic [1:0] fwdSel(input logic [4:0] rs);
        if (RegWrite_EM && (RD_EM != 5'd0) && (RD_EM == rs) && (MemRead_EM == 2'd0))
            fwdSel = 2'b10;
        else if (RegWrite_MW && (RD_MW != 5'd0) && (RD_MW == rs))
            fwdSel = 2'b01;
        else
            fwdSel = 2'b00;
    endfunction

    // Hazard detection terms. DM_READY without a pending access drops out
    // naturally because memBusy requires an access in MEM.
    always_comb begin
        memBusy = ((MemRead_EM != 2'd0) || (MemWrite_EM != 2'd0)) && !DM_READY;
        loadUse = (MemRead_DE != 2'd0) && (RD_DE != 5'd0) &&
                  ((USES_RS1_ID && (RS1_ID == RD_DE)) ||
                   (USES_RS2_ID && (RS2_ID == RD_DE)));
    end

    // Control priority: freeze, then squash, then load-use bubble. A branch
    // that resolves during a freeze keeps TAKEN_E high, so its flush simply
    // happens on the first unfrozen cycle.
    always_comb begin
        stall_PC = 1'b0;
        stall_FD = 1'b0;
        stall_DE = 1'b0;
        flush_FD = 1'b0;
        flush_DE = 1'b0;
        FREEZE   = memBusy;
        if (memBusy) begin
            stall_PC = 1'b1;
            stall_FD = 1'b1;
        end else if (TAKEN_E) begin
            flush_FD = 1'b1;
            flush_DE = 1'b1;
        end else if (loadUse) begin
            stall_PC = 1'b1;
            stall_FD = 1'b1;
            stall_DE = 1'b1;
        end
    end

    always_comb begin
        FWD_A = fwdSel(RS1_DE);
        FWD_B = fwdSel(RS2_DE);
    end

    // Memory-wait state machine: next state, wait counter and error flag.
    // The counter saturates so the error condition stays visible while the
    // memory keeps holding off.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            RUN: begin
                if (memBusy) begin
                    state_d    = WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            WAIT: begin
                if (wait_cnt_q == TIMEOUT_VAL)
                    timeout_err_d = 1'b1;
                if (DM_READY) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < TIMEOUT_VAL) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign TIMEOUT_ERR = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    // Counters wrap naturally modulo 2^CNT_W.
    always_comb begin
        stall_cnt_d  = stall_cnt_q  + CNT_W'(stall_DE);
        flush_cnt_d  = flush_cnt_q  + CNT_W'(flush_DE);
        freeze_cnt_d = freeze_cnt_q + CNT_W'(FREEZE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign STALL_CNT  = stall_cnt_q;
    assign FLUSH_CNT  = flush_cnt_q;
    assign FREEZE_CNT = freeze_cnt_q;
`else
    assign STALL_CNT  = '0;
    assign FLUSH_CNT  = '0;
    assign FREEZE_CNT = '0;
`endif

endmodule
